// File: rtl/i2c_slave_pkg.sv
// Shared types and helpers for the I2C slave register-file back end.
package i2c_slave_pkg;

  typedef enum logic {
    S_PTR  = 1'b0,
    S_DATA = 1'b1
  } state_t;

  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h27;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/i2c_event_edge.sv
// Rising-edge detector against a registered history bit; a held-high level yields one event.
module i2c_event_edge (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic hist_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_p0 <= 1'b0;
    else       hist_p0 <= in;
  end

  assign rise = in & ~hist_p0;

endmodule

// File: rtl/i2c_slave_regfile.sv
// Register file behind the I2C slave: pointer byte, auto-increment writes, reads from the pointer,
// plus a parallel application port onto the same registers.
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR   = DEF_SLAVE_ADDR,
  parameter int         NREGS        = 16,
  parameter int         IDLE_TIMEOUT = 1000,
  localparam int        IDXW         = clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [6:0]      address,
  input  logic [7:0]      datareceive,
  input  logic            received,
  output logic [7:0]      datasend,
  input  logic            sended,
  input  logic [IDXW-1:0] app_addr,
  input  logic [7:0]      app_wdata,
  input  logic            app_we,
  output logic [7:0]      app_rdata,
  output logic            wr_strobe,
  output logic [IDXW-1:0] wr_index
);

  localparam int              CNTW     = clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNTW-1:0] IDLE_MAX = CNTW'(IDLE_TIMEOUT);

  logic            rx_ev, tx_ev;
  state_t          state, state_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [CNTW-1:0] idle_cnt;
  logic            i2c_we;
  logic [7:0]      regs [NREGS];

  assign address = SLAVE_ADDR;

  i2c_event_edge u_rx_edge (.clk(clk), .reset(reset), .in(received), .rise(rx_ev));
  i2c_event_edge u_tx_edge (.clk(clk), .reset(reset), .in(sended),   .rise(tx_ev));

  // rx wins over a coincident tx so the pointer advances only once
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    i2c_we    = 1'b0;
    if (idle_cnt == IDLE_MAX) state_nxt = S_PTR;
    if (rx_ev) begin
      if (state == S_PTR) begin
        ptr_nxt   = datareceive[IDXW-1:0];
        state_nxt = S_DATA;
      end else begin
        i2c_we  = 1'b1;
        ptr_nxt = ptr + 1'b1;
      end
    end else if (tx_ev) begin
      ptr_nxt = ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_PTR;
      ptr      <= '0;
      idle_cnt <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (rx_ev || tx_ev)         idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // I2C write takes priority when both ports hit the same register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i2c_we && ptr == IDXW'(i))          regs[i] <= datareceive;
        else if (app_we && app_addr == IDXW'(i)) regs[i] <= app_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      datasend  <= '0;
      app_rdata <= '0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
    end else begin
      datasend  <= regs[ptr];
      app_rdata <= regs[app_addr];
      wr_strobe <= i2c_we;
      if (i2c_we) wr_index <= ptr;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: pointer/write sequences, wrap, idle re-arm, collisions, reset.
module tb_i2c_slave_regfile;

  localparam int NREGS = 16;
  localparam int TO    = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] address;
  logic [7:0] datareceive;
  logic       received;
  logic [7:0] datasend;
  logic       sended;
  logic [3:0] app_addr;
  logic [7:0] app_wdata;
  logic       app_we;
  logic [7:0] app_rdata;
  logic       wr_strobe;
  logic [3:0] wr_index;

  int errors = 0;
  int checks = 0;

  logic       s;
  logic [3:0] idx;
  int         nstrobe;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h27), .NREGS(NREGS), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .address(address),
    .datareceive(datareceive), .received(received), .datasend(datasend), .sended(sended),
    .app_addr(app_addr), .app_wdata(app_wdata), .app_we(app_we), .app_rdata(app_rdata),
    .wr_strobe(wr_strobe), .wr_index(wr_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx(input logic [7:0] b, output logic strobe, output logic [3:0] index);
    datareceive = b;
    received    = 1'b1;
    tick();
    strobe   = wr_strobe;
    index    = wr_index;
    received = 1'b0;
    tick();
    tick();
  endtask

  task automatic tx();
    sended = 1'b1;
    tick();
    sended = 1'b0;
    tick();
    tick();
  endtask

  task automatic app_write(input logic [3:0] a, input logic [7:0] d);
    app_addr  = a;
    app_wdata = d;
    app_we    = 1'b1;
    tick();
    app_we = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
    app_addr = a;
    tick();
    check(tag, app_rdata, exp);
  endtask

  task automatic wait_idle();
    repeat (TO + 5) tick();
  endtask

  initial begin
    reset = 1'b1; datareceive = '0; received = 1'b0; sended = 1'b0;
    app_addr = '0; app_wdata = '0; app_we = 1'b0;
    repeat (3) tick();
    check("rst address", address, 7'h27);
    check("rst datasend", datasend, 8'h00);
    check("rst app_rdata", app_rdata, 8'h00);
    check("rst wr_strobe", wr_strobe, 1'b0);
    check("rst wr_index", wr_index, 4'h0);
    reset = 1'b0;
    tick();

    app_write(4'd5, 8'hC5); app_write(4'd1, 8'hB1); app_write(4'd2, 8'h12);
    app_write(4'd7, 8'h77); app_write(4'd6, 8'h66); app_write(4'd8, 8'h88);
    app_write(4'd9, 8'h99);
    check_reg("app rw 5", 4'd5, 8'hC5);

    // 1: pointer then two auto-increment writes
    rx(8'h03, s, idx); check("t1 ptr strobe", s, 1'b0);
    rx(8'hA5, s, idx); check("t1 w0 strobe", s, 1'b1); check("t1 w0 index", idx, 4'd3);
    rx(8'h5A, s, idx); check("t1 w1 strobe", s, 1'b1); check("t1 w1 index", idx, 4'd4);
    check("t1 ptr=5", datasend, 8'hC5);
    check_reg("t1 reg3", 4'd3, 8'hA5);
    check_reg("t1 reg4", 4'd4, 8'h5A);

    // 2: pointer wrap
    wait_idle();
    rx(8'h0F, s, idx); check("t2 ptr strobe", s, 1'b0);
    rx(8'h11, s, idx); check("t2 w0 strobe", s, 1'b1); check("t2 w0 index", idx, 4'd15);
    rx(8'h22, s, idx); check("t2 w1 strobe", s, 1'b1); check("t2 w1 index", idx, 4'd0);
    check("t2 ptr=1", datasend, 8'hB1);
    check_reg("t2 reg15", 4'd15, 8'h11);
    check_reg("t2 reg0", 4'd0, 8'h22);

    // 3: idle re-arm and reads
    wait_idle();
    rx(8'h02, s, idx); check("t3 ptr strobe", s, 1'b0);
    repeat (TO + 2) tick();
    check("t3 datasend reg2", datasend, 8'h12);
    tx(); check("t3 read reg3", datasend, 8'hA5);
    tx(); check("t3 read reg4", datasend, 8'h5A);
    rx(8'h07, s, idx); check("t3 rearm no strobe", s, 1'b0);
    check("t3 ptr=7", datasend, 8'h77);

    // 4: level held high counts once
    wait_idle();
    datareceive = 8'h01;
    received    = 1'b1;
    nstrobe     = 0;
    repeat (50) begin
      tick();
      if (wr_strobe) nstrobe++;
    end
    received = 1'b0;
    tick(); tick();
    check("t4 held strobes", 16'(nstrobe), 16'd0);
    check("t4 ptr=1", datasend, 8'hB1);
    rx(8'h44, s, idx); check("t4 data state strobe", s, 1'b1); check("t4 data index", idx, 4'd1);
    check("t4 ptr=2", datasend, 8'h12);

    // 5: I2C and application write collisions
    wait_idle();
    rx(8'h06, s, idx);
    datareceive = 8'h33; received = 1'b1;
    app_addr = 4'd6; app_wdata = 8'hFF; app_we = 1'b1;
    tick();
    received = 1'b0; app_we = 1'b0;
    tick();
    check_reg("t5 same idx", 4'd6, 8'h33);
    app_write(4'd6, 8'h66);
    wait_idle();
    rx(8'h06, s, idx);
    datareceive = 8'h33; received = 1'b1;
    app_addr = 4'd7; app_wdata = 8'hFF; app_we = 1'b1;
    tick();
    received = 1'b0; app_we = 1'b0;
    tick();
    check_reg("t5 diff idx reg6", 4'd6, 8'h33);
    check_reg("t5 diff idx reg7", 4'd7, 8'hFF);

    // simultaneous rx and tx: pointer advances once
    datareceive = 8'h5C; received = 1'b1; sended = 1'b1;
    tick();
    received = 1'b0; sended = 1'b0;
    tick(); tick();
    check("rxtx ptr=8", datasend, 8'h88);
    check_reg("rxtx reg7", 4'd7, 8'h5C);

    // 6: reset between pointer and data byte
    wait_idle();
    rx(8'h03, s, idx);
    app_addr = 4'd3;
    tick();
    reset = 1'b1;
    tick();
    check("t6 rst datasend", datasend, 8'h00);
    check("t6 rst app_rdata", app_rdata, 8'h00);
    check("t6 rst wr_strobe", wr_strobe, 1'b0);
    check("t6 rst wr_index", wr_index, 4'h0);
    reset = 1'b0;
    tick();
    app_write(4'd9, 8'h99);
    rx(8'h09, s, idx); check("t6 ptr strobe", s, 1'b0);
    check("t6 ptr=9", datasend, 8'h99);
    check_reg("t6 reg0", 4'd0, 8'h00);
    check_reg("t6 reg3 cleared", 4'd3, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
